// File: rtl/i2c_slave.sv
// I2C slave at address SLAVE_ADDR; bus events act 3 clk after the pin change, no backpressure.
// Define I2C_SLAVE_GENCALL_EN to also ack general-call (address byte 8'h00) as a write.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h28
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy,
  output logic [3:0] state_r
);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    WR_DATA   = 4'd3,
    WR_ACK    = 4'd4,
    RD_DATA   = 4'd5,
    RD_ACK    = 4'd6,
    WAIT_STOP = 4'd7
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  scl_sync_q, sda_sync_q;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [6:0]  tx_shift_q, tx_shift_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_req_q, tx_req_d;

  logic        scl_now, scl_prev, sda_now, sda_prev;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  byte_in;
  logic        addr_hit;

  // Stage [1] is the synchronized value, stage [2] the one-clk delay used for edges.
  assign scl_now   = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda_now   = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_now;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_now;
  assign byte_in   = {shift_q, sda_now};

`ifdef I2C_SLAVE_GENCALL_EN
  assign addr_hit = ((byte_in[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00)) ||
                    (byte_in == 8'h00);
`else
  assign addr_hit = (byte_in[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00);
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;

    if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (addr_hit) begin
                state_d  = ADDR_ACK;
                rw_d     = byte_in[0];
                tx_req_d = byte_in[0];
              end else begin
                state_d = WAIT_STOP;
              end
            end
          end
        end
        // Count 8 marks the fall that starts the ack; the 9th rise wraps it to 0.
        ADDR_ACK, WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_d = 4'd0;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b1;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d    = RD_DATA;
              tx_shift_d = tx_data[6:0];
              sda_oe_d   = ~tx_data[7];
            end else begin
              state_d  = WR_DATA;
              sda_oe_d = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = byte_in;
              rx_valid_d = 1'b1;
              state_d    = WR_ACK;
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) state_d = RD_ACK;
          end else if (scl_fall) begin
            // A fall at count 0 follows a master ACK: load the next byte.
            if (bit_cnt_q == 4'd0) begin
              tx_shift_d = tx_data[6:0];
              sda_oe_d   = ~tx_data[7];
            end else begin
              tx_shift_d = {tx_shift_q[5:0], 1'b0};
              sda_oe_d   = ~tx_shift_q[6];
            end
          end
        end
        RD_ACK: begin
          if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
          end else if (scl_rise) begin
            bit_cnt_d = 4'd0;
            if (!sda_now) begin
              tx_req_d = 1'b1;
              state_d  = RD_DATA;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        IDLE, WAIT_STOP: ;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 7'd0;
      tx_shift_q <= 7'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= {scl_sync_q[1:0], SCL};
      sda_sync_q <= {sda_sync_q[1:0], SDA};
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
    end
  end

  assign SDA      = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = (state_q != IDLE);
  assign state_r  = state_q;

endmodule
